// File: rtl/core_cmd_arbiter_pkg.sv
// rtl/core_cmd_arbiter_pkg.sv - shared types and constants for the core command arbiter
package core_cmd_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    localparam int INSTR_W = 12;
    localparam int OP_LSB  = 9;
    localparam int RD_LSB  = 6;
    localparam int RS1_LSB = 3;
    localparam int RS2_LSB = 0;

    // Opcodes understood by the shared ALU
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_SHR = 3'd6;
    localparam logic [2:0] OP_MOV = 3'd7;

    function automatic logic [2:0] instr_field(input logic [INSTR_W-1:0] instr, input int lsb);
        return instr[lsb +: 3];
    endfunction

endpackage

// File: rtl/core_cmd_arbiter_rr_pick.sv
// rtl/core_cmd_arbiter_rr_pick.sv - combinational round-robin priority select
module rr_pick #(
    parameter int N    = 2,
    parameter int ID_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] last_grant,
    output logic [ID_W-1:0] winner,
    output logic            any_valid
);

    int idx;

    // Scan starts just after the previous winner so it gets lowest priority
    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        idx       = 0;
        for (int i = 1; i <= N; i++) begin
            idx = (int'(last_grant) + i) % N;
            if (!any_valid && req[idx]) begin
                any_valid = 1'b1;
                winner    = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/core_cmd_arbiter.sv
// rtl/core_cmd_arbiter.sv - round-robin sharing of the ALU core between requesters
module core_cmd_arbiter
    import core_cmd_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 8,
    parameter int CNT_W   = 16,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [INSTR_W*NUM_REQ-1:0] req_instr,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [ID_W-1:0]            resp_id,
    output logic                       resp_z,
    output logic                       resp_c,
    output logic                       resp_err,
    output logic                       start_cmd,
    output logic [2:0]                 op_out,
    output logic [2:0]                 rd_out,
    output logic [2:0]                 rs1_out,
    output logic [2:0]                 rs2_out,
    input  logic                       cmd_done,
    input  logic                       z_flag_in,
    input  logic                       c_flag_in,
    output logic                       busy,
    output logic [CNT_W-1:0]           done_count,
    output logic [CNT_W-1:0]           err_count
);

    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    arb_state_t           state, next_state;
    logic [ID_W-1:0]      last_grant, winner, winner_q;
    logic                 any_valid;
    logic [INSTR_W-1:0]   instr_q, instr_sel;
    logic [TW-1:0]        timer;

    rr_pick #(.N(NUM_REQ), .ID_W(ID_W)) u_rr_pick (
        .req        (req_valid),
        .last_grant (last_grant),
        .winner     (winner),
        .any_valid  (any_valid)
    );

    assign instr_sel  = req_instr[int'(winner)*INSTR_W +: INSTR_W];
    assign op_out     = instr_field(instr_q, OP_LSB);
    assign rd_out     = instr_field(instr_q, RD_LSB);
    assign rs1_out    = instr_field(instr_q, RS1_LSB);
    assign rs2_out    = instr_field(instr_q, RS2_LSB);
    assign resp_valid = (state == RESP);
    assign busy       = (state != IDLE);
    assign resp_id    = winner_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        req_ready  = '0;
        case (state)
            IDLE: if (any_valid) begin
                req_ready[winner] = 1'b1;
                next_state        = ISSUE;
            end
            ISSUE: next_state = WAIT;
            WAIT:  if (cmd_done || timer == TIMER_LAST) next_state = RESP;
            RESP:  if (resp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_cmd  <= 1'b0;
            instr_q    <= '0;
            winner_q   <= '0;
            last_grant <= ID_W'(NUM_REQ - 1);
            timer      <= '0;
            resp_z     <= 1'b0;
            resp_c     <= 1'b0;
            resp_err   <= 1'b0;
            done_count <= '0;
            err_count  <= '0;
        end else begin
            start_cmd <= 1'b0;
            case (state)
                IDLE: if (any_valid) begin
                    instr_q   <= instr_sel;
                    winner_q  <= winner;
                    start_cmd <= 1'b1;
                end
                ISSUE: timer <= '0;
                // A completion arriving on the timeout cycle still counts as done
                WAIT: if (cmd_done) begin
                    resp_z   <= z_flag_in;
                    resp_c   <= c_flag_in;
                    resp_err <= 1'b0;
                    if (done_count != '1) done_count <= done_count + 1'b1;
                end else if (timer == TIMER_LAST) begin
                    resp_z   <= 1'b0;
                    resp_c   <= 1'b0;
                    resp_err <= 1'b1;
                    if (err_count != '1) err_count <= err_count + 1'b1;
                end else begin
                    timer <= timer + 1'b1;
                end
                RESP: if (resp_ready) last_grant <= winner_q;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_core_cmd_arbiter.sv
// tb/tb_core_cmd_arbiter.sv - directed self-checking bench for core_cmd_arbiter
module tb_core_cmd_arbiter;

    localparam int NR = 2;
    localparam int TO = 8;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [NR-1:0] req_valid;
    logic [NR-1:0] req_ready;
    logic [12*NR-1:0] req_instr;
    logic          resp_valid, resp_ready;
    logic [0:0]    resp_id;
    logic          resp_z, resp_c, resp_err;
    logic          start_cmd;
    logic [2:0]    op_out, rd_out, rs1_out, rs2_out;
    logic          cmd_done, z_flag_in, c_flag_in;
    logic          busy;
    logic [CW-1:0] done_count, err_count;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [11:0] INSTR0 = 12'h081;
    localparam logic [11:0] INSTR1 = 12'h5A3;

    core_cmd_arbiter #(.NUM_REQ(NR), .TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_instr(req_instr),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_z(resp_z), .resp_c(resp_c), .resp_err(resp_err),
        .start_cmd(start_cmd),
        .op_out(op_out), .rd_out(rd_out), .rs1_out(rs1_out), .rs2_out(rs2_out),
        .cmd_done(cmd_done), .z_flag_in(z_flag_in), .c_flag_in(c_flag_in),
        .busy(busy), .done_count(done_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Full 5-cycle command: accept, issue, wait, core done, response taken
    task automatic run_cmd(input int id, input logic [11:0] ins, input logic z, input logic c,
                           input int exp_done);
        #1;
        chk("accept_ready", 32'(req_ready), 32'(1 << id));
        chk("accept_nostart", 32'(start_cmd), 32'd0);
        tick();
        chk("issue_start", 32'(start_cmd), 32'd1);
        chk("issue_fields", 32'({op_out, rd_out, rs1_out, rs2_out}), 32'(ins));
        chk("issue_ready0", 32'(req_ready), 32'd0);
        tick();
        chk("wait_start0", 32'(start_cmd), 32'd0);
        tick();
        cmd_done = 1'b1; z_flag_in = z; c_flag_in = c;
        chk("done_cyc_noresp", 32'(resp_valid), 32'd0);
        tick();
        cmd_done = 1'b0; z_flag_in = ~z; c_flag_in = ~c;
        chk("resp_valid", 32'(resp_valid), 32'd1);
        chk("resp_id", 32'(resp_id), 32'(id));
        chk("resp_flags", 32'({resp_z, resp_c, resp_err}), 32'({z, c, 1'b0}));
        chk("done_count", 32'(done_count), 32'(exp_done));
        tick();
        chk("back_idle", 32'(resp_valid), 32'd0);
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_instr = {INSTR1, INSTR0};
        resp_ready = 1'b1; cmd_done = 1'b0; z_flag_in = 1'b0; c_flag_in = 1'b0;
        #1;
        chk("rst_outputs", 32'({req_ready, resp_valid, start_cmd, busy, resp_id, resp_err}), 32'd0);
        chk("rst_counts", 32'({done_count, err_count}), 32'd0);
        tick(); tick();
        rst = 1'b0;

        // Single command from requester 0
        req_valid = 2'b01;
        run_cmd(0, INSTR0, 1'b1, 1'b0, 1);
        req_valid = 2'b00;

        // Spurious completion in IDLE
        cmd_done = 1'b1;
        tick();
        cmd_done = 1'b0;
        chk("spur_idle", 32'({busy, resp_valid}), 32'd0);
        chk("spur_count", 32'(done_count), 32'd1);

        // Back-pressure on requester 1's response
        req_valid = 2'b10; resp_ready = 1'b0;
        #1;
        chk("bp_accept", 32'(req_ready), 32'b10);
        tick();
        req_valid = 2'b00;
        tick(); tick();
        cmd_done = 1'b1; z_flag_in = 1'b0; c_flag_in = 1'b1;
        tick();
        cmd_done = 1'b0; z_flag_in = 1'b1; c_flag_in = 1'b0;
        req_valid = 2'b11;
        for (int k = 0; k < 10; k++) begin
            chk("bp_hold", 32'({resp_valid, resp_id, resp_z, resp_c, resp_err}), 32'b11010);
            chk("bp_block", 32'({req_ready, start_cmd, busy}), 32'b0001);
            tick();
        end
        chk("bp_done_count", 32'(done_count), 32'd2);
        req_valid = 2'b00; resp_ready = 1'b1;
        tick();
        chk("bp_release", 32'({busy, resp_valid}), 32'd0);

        // Timeout: core never answers
        req_valid = 2'b01; z_flag_in = 1'b1; c_flag_in = 1'b1;
        #1;
        chk("to_accept", 32'(req_ready), 32'b01);
        tick();
        req_valid = 2'b00;
        for (int k = 0; k < 8; k++) tick();
        chk("to_not_yet", 32'({resp_valid, busy}), 32'b01);
        resp_ready = 1'b0;
        tick();
        chk("to_resp", 32'({resp_valid, resp_id, resp_z, resp_c, resp_err}), 32'b10001);
        chk("to_err_count", 32'(err_count), 32'd1);
        cmd_done = 1'b1;
        tick();
        cmd_done = 1'b0;
        chk("late_done_ignored", 32'({resp_valid, resp_err, done_count}), 32'({2'b11, 3'd2}));
        resp_ready = 1'b1;
        tick();
        chk("to_release", 32'(busy), 32'd0);

        // Reset in WAIT abandons the command
        req_valid = 2'b10;
        #1;
        chk("rw_accept", 32'(req_ready), 32'b10);
        tick();
        req_valid = 2'b00;
        chk("rw_start", 32'(start_cmd), 32'd1);
        tick();
        chk("rw_wait_busy", 32'(busy), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("rw_async", 32'({start_cmd, busy, resp_valid}), 32'd0);
        chk("rw_counts", 32'({done_count, err_count}), 32'd0);
        tick();
        rst = 1'b0;
        cmd_done = 1'b1;
        tick();
        cmd_done = 1'b0;
        tick();
        chk("rw_noresp", 32'({resp_valid, busy, done_count}), 32'd0);

        // Contention: alternating grants starting at requester 0
        req_valid = 2'b11;
        run_cmd(0, INSTR0, 1'b1, 1'b1, 1);
        run_cmd(1, INSTR1, 1'b0, 1'b0, 2);
        run_cmd(0, INSTR0, 1'b1, 1'b0, 3);
        run_cmd(1, INSTR1, 1'b0, 1'b1, 4);

        // Single requester back-to-back, counter saturates at 7
        req_valid = 2'b01;
        run_cmd(0, INSTR0, 1'b0, 1'b0, 5);
        run_cmd(0, INSTR0, 1'b1, 1'b1, 6);
        run_cmd(0, INSTR0, 1'b0, 1'b1, 7);
        run_cmd(0, INSTR0, 1'b1, 1'b0, 7);
        req_valid = 2'b00;
        chk("sat_err_count", 32'(err_count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/core_cmd_arbiter.md
Name: core_cmd_arbiter

Overview:
- Shares the single 8-bit ALU/register-file core between NUM_REQ independent requesters.
- Accepts 12-bit instructions over per-requester valid/ready handshakes and picks a winner round-robin.
- Issues one start_cmd pulse to the core and waits for cmd_done, with a watchdog on the wait.
- Returns one response per instruction: requester id, captured Z/C flags and an error bit.

Parameters:
NUM_REQ, 2, number of requesters, legal range 2..8.
TIMEOUT, 8, max WAIT cycles before a command is declared lost, >=4.
CNT_W, 16, width of the statistics counters.

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous reset, active-high
req_valid  in  NUM_REQ  per-requester command valid
req_ready  out  NUM_REQ  per-requester accept, one-hot or zero
req_instr  in  12*NUM_REQ  slot i = bits [12i+11:12i] = {op[2:0],rd[2:0],rs1[2:0],rs2[2:0]}
resp_valid  out  1  response available
resp_ready  in  1  response consumer accept
resp_id  out  ID_W  index of the requester served, ID_W = clog2(NUM_REQ)
resp_z  out  1  Z flag captured at cmd_done
resp_c  out  1  C flag captured at cmd_done
resp_err  out  1  command timed out; resp_z/resp_c forced 0
start_cmd  out  1  one-cycle command pulse to core
op_out, rd_out, rs1_out, rs2_out  out  3 each  instruction fields to core, held stable from ISSUE through WAIT
cmd_done  in  1  core completion strobe
z_flag_in, c_flag_in  in  1 each  core ALU flags, valid in the cmd_done cycle
busy  out  1  high in any state other than IDLE
done_count  out  CNT_W  completed commands, saturating
err_count  out  CNT_W  timed-out commands, saturating

Behaviour:
- Reset values:
  - All outputs 0; state IDLE.
  - RR pointer last_grant = NUM_REQ-1, so requester 0 wins first.
  - Counters and timer 0.
- State machine, four states:
  - IDLE:
    - If any req_valid: winner = first valid index scanning last_grant+1 upward, modulo NUM_REQ.
    - req_ready[winner]=1 combinationally this cycle; latch instr and winner; -> ISSUE.
    - Otherwise stay. req_ready is 0 in every other state.
  - ISSUE: start_cmd=1 for exactly this cycle (registered); timer cleared; -> WAIT.
  - WAIT:
    - If cmd_done: capture z_flag_in/c_flag_in, resp_err=0, done_count+1; -> RESP.
    - Else if timer==TIMEOUT-1: resp_err=1, flags 0, err_count+1; -> RESP.
    - Else timer+1.
  - RESP:
    - resp_valid=1; resp_id/resp_z/resp_c/resp_err stable while waiting.
    - On resp_ready: last_grant = latched winner; -> IDLE.
- Latency with the current core (cmd_done two cycles after start is sampled):
  - Accept at cycle N, ISSUE N+1, cmd_done N+3, resp_valid from N+4.
  - Back-to-back throughput: one command per 5 cycles.
- Requester rules: hold req_valid and req_instr stable until req_ready. Dropping valid early is a protocol violation; the arbiter ignores slots whose valid is low at the sampling cycle.
- Boundary conditions:
  - cmd_done and the timeout in the same cycle: done wins, no error.
  - cmd_done in IDLE, ISSUE or RESP (spurious or late after a timeout): ignored, no state or counter change.
  - resp_ready held low: remain in RESP indefinitely; no new acceptance and no start_cmd.
  - Counters saturate at all-ones; no wrap.
  - rst asserted in any state: immediate return to reset values. start_cmd drops asynchronously; no response is produced for the in-flight command.
  - Integration ties the core's active-low reset to ~rst, so both restart together.
  - Single valid requester: served repeatedly, with no dead cycle beyond the 5-cycle loop.

Decomposition:
- Shared package:
  - State encoding localparams: IDLE, ISSUE, WAIT, RESP.
  - INSTR_W=12 and field offsets OP_LSB=9, RD_LSB=6, RS1_LSB=3, RS2_LSB=0.
  - The 3-bit opcode constants already used by the ALU.
- One sub-module: rr_pick.
  - Combinational round-robin priority select.
  - Inputs: req vector and last_grant. Outputs: winner index and any_valid.
  - Reusable for future shared resources.
- FSM, timer, latches and counters stay in core_cmd_arbiter.

Test Plan:
- Single command: req_valid=01, instr {op=000,rd=2,rs1=0,rs2=1}, resp_ready=1.
  - -> req_ready[0] high 1 cycle; start_cmd 1 cycle later.
  - -> resp_valid 4 cycles after accept with resp_id=0, resp_err=0, resp_z/c equal to the core flags in the cmd_done cycle; done_count=1.
- Contention: both req_valid held high for 4 commands.
  - -> grant order 0,1,0,1; each resp_id matches; responses spaced 5 cycles.
- Back-pressure: resp_ready=0 for 10 cycles after resp_valid.
  - -> outputs stable, busy=1, req_ready=0, no start_cmd.
  - -> resp_ready=1 returns to IDLE next cycle.
- Timeout: core stub never asserts cmd_done, TIMEOUT=8.
  - -> resp_valid 8 WAIT cycles after ISSUE with resp_err=1, resp_z=resp_c=0, err_count=1.
  - -> a late cmd_done after the timeout is ignored.
- Reset mid-WAIT: assert rst for 1 cycle.
  - -> start_cmd, busy and counters 0; no response.
  - -> next contention is granted to requester 0.
- Spurious cmd_done pulse in IDLE: no state change; done_count unchanged.
